// File: rtl/pht_update_queue.sv
// Write-back queue between branch resolution and the single-ported gshare PHT.
// Filters no-change updates, buffers the rest, and drains when fetch leaves the port idle or the queue is full.

module pht_update_queue_chk #(
  parameter int QUEUE_SIZE = 32,
  parameter int CNT_W      = 6
) (
  input logic             clk,
  input logic             rst,
  input logic [CNT_W-1:0] count
);
  a_count_bound: assert property (@(posedge clk) disable iff (!rst) count <= CNT_W'(QUEUE_SIZE));
endmodule

module pht_update_queue #(
  parameter int QUEUE_SIZE          = 32,
  parameter int PC_WIDTH            = 32,
  parameter int INSN_ADDR_BIT_WIDTH = 2,
  parameter int PHT_INDEX_WIDTH     = 10,
  parameter int GHR_WIDTH           = 10,
  parameter int COUNTER_WIDTH       = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           br_valid,
  input  logic                           br_is_cond,
  input  logic                           br_exec_taken,
  input  logic [PC_WIDTH-1:0]            br_addr,
  input  logic [GHR_WIDTH-1:0]           br_global_history,
  input  logic [COUNTER_WIDTH-1:0]       br_pht_prev,
  input  logic                           pht_read_req,
  output logic                           pht_we,
  output logic [PHT_INDEX_WIDTH-1:0]     pht_wa,
  output logic [COUNTER_WIDTH-1:0]      pht_wv,
  output logic                           pht_read_blocked,
  output logic [$clog2(QUEUE_SIZE+1)-1:0] count,
  output logic                           full,
  output logic                           empty
);
  localparam int PTR_W   = $clog2(QUEUE_SIZE);
  localparam int CNT_W   = $clog2(QUEUE_SIZE + 1);
  localparam int ENTRY_W = PHT_INDEX_WIDTH + COUNTER_WIDTH;
  localparam int IDX_LO  = INSN_ADDR_BIT_WIDTH;
  localparam int IDX_HI  = INSN_ADDR_BIT_WIDTH + PHT_INDEX_WIDTH - 1;

  // Saturating 2-bit style counter step; never wraps at either end.
  function automatic logic [COUNTER_WIDTH-1:0] f_next_counter(
    input logic [COUNTER_WIDTH-1:0] prev,
    input logic                     taken
  );
    logic [COUNTER_WIDTH-1:0] max_v;
    max_v = {COUNTER_WIDTH{1'b1}};
    if (taken) begin
      if (prev == max_v) return prev;
      else               return prev + COUNTER_WIDTH'(1);
    end else begin
      if (prev == {COUNTER_WIDTH{1'b0}}) return prev;
      else                               return prev - COUNTER_WIDTH'(1);
    end
  endfunction

  logic [ENTRY_W-1:0]         r_mem [QUEUE_SIZE];
  logic [PTR_W-1:0]           r_head;
  logic [PTR_W-1:0]           r_tail;
  logic [CNT_W-1:0]           r_count;
  logic                       r_full;
  logic                       r_empty;

  logic [PHT_INDEX_WIDTH-1:0] w_idx;
  logic [COUNTER_WIDTH-1:0]   w_new;
  logic                       w_enq;
  logic                       w_deq;
  logic [CNT_W-1:0]           w_count_nxt;
  logic [ENTRY_W-1:0]         w_head_entry;
  logic                       w_unused_addr;

  assign w_idx = br_addr[IDX_HI:IDX_LO] ^ PHT_INDEX_WIDTH'(br_global_history);
  assign w_new = f_next_counter(br_pht_prev, br_exec_taken);
  assign w_enq = br_valid & br_is_cond & (w_new != br_pht_prev);
  assign w_unused_addr = ^{br_addr[PC_WIDTH-1:IDX_HI+1], br_addr[IDX_LO-1:0]};

  // Forced drain when full guarantees a same-cycle enqueue always has room.
  assign w_deq            = ~r_empty & (~pht_read_req | r_full);
  assign pht_we           = w_deq;
  assign pht_read_blocked = w_deq & pht_read_req;
  assign w_head_entry     = r_mem[r_head];
  assign pht_wa           = w_head_entry[ENTRY_W-1:COUNTER_WIDTH];
  assign pht_wv           = w_head_entry[COUNTER_WIDTH-1:0];
  assign count            = r_count;
  assign full             = r_full;
  assign empty            = r_empty;

  // Occupancy update from the enqueue/dequeue pair.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_enq, w_deq})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Storage write; contents intentionally survive reset.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_mem[r_tail] <= {w_idx, w_new};
    end
  end

  // Pointers, occupancy and status flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= {PTR_W{1'b0}};
      r_tail  <= {PTR_W{1'b0}};
      r_count <= {CNT_W{1'b0}};
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (w_enq) r_tail <= r_tail + PTR_W'(1);
      if (w_deq) r_head <= r_head + PTR_W'(1);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CNT_W'(QUEUE_SIZE));
      r_empty <= (w_count_nxt == {CNT_W{1'b0}});
    end
  end

  pht_update_queue_chk #(
    .QUEUE_SIZE (QUEUE_SIZE),
    .CNT_W      (CNT_W)
  ) u_chk (
    .clk   (clk),
    .rst   (rst),
    .count (r_count)
  );
endmodule

// File: tb/tb_pht_update_queue.sv
// Self-checking bench for pht_update_queue: randomized and directed stimulus against a queue-based model.

module tb_pht_update_queue;
  logic        clk;
  logic        rst;
  logic        br_valid;
  logic        br_is_cond;
  logic        br_exec_taken;
  logic [31:0] br_addr;
  logic [9:0]  br_global_history;
  logic [1:0]  br_pht_prev;
  logic        pht_read_req;
  logic        pht_we;
  logic [9:0]  pht_wa;
  logic [1:0]  pht_wv;
  logic        pht_read_blocked;
  logic [5:0]  count;
  logic        full;
  logic        empty;

  int n_checks = 0;
  int n_fail   = 0;

  logic [11:0] mq[$];
  logic [9:0]  exp_status;
  logic [11:0] exp_head;
  logic        exp_we;
  wire  [9:0]  obs_status = {pht_we, pht_read_blocked, count, full, empty};
  wire  [11:0] obs_head   = {pht_wa, pht_wv};

  pht_update_queue dut (
    .clk               (clk),
    .rst               (rst),
    .br_valid          (br_valid),
    .br_is_cond        (br_is_cond),
    .br_exec_taken     (br_exec_taken),
    .br_addr           (br_addr),
    .br_global_history (br_global_history),
    .br_pht_prev       (br_pht_prev),
    .pht_read_req      (pht_read_req),
    .pht_we            (pht_we),
    .pht_wa            (pht_wa),
    .pht_wv            (pht_wv),
    .pht_read_blocked  (pht_read_blocked),
    .count             (count),
    .full              (full),
    .empty             (empty)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Apply inputs mid-cycle and derive expected outputs from the model queue.
  task automatic drive(input logic v, input logic c, input logic t, input logic [31:0] a,
                       input logic [9:0] h, input logic [1:0] p, input logic rd);
    int sz;
    @(negedge clk);
    br_valid = v; br_is_cond = c; br_exec_taken = t;
    br_addr = a; br_global_history = h; br_pht_prev = p; pht_read_req = rd;
    #1;
    sz = mq.size();
    exp_we = (sz != 0) && (!rd || sz == 32);
    exp_status = {exp_we, exp_we & rd, 6'(sz), sz == 32, sz == 0};
    exp_head = (sz != 0) ? mq[0] : 12'h000;
  endtask

  // Advance one edge and apply the queue semantics to the model.
  task automatic tick();
    int pv, nv, idx;
    @(posedge clk);
    if (exp_we) void'(mq.pop_front());
    pv = int'(br_pht_prev);
    if (br_exec_taken) nv = (pv + 1 > 3) ? 3 : pv + 1;
    else               nv = (pv - 1 < 0) ? 0 : pv - 1;
    idx = int'((br_addr >> 2) & 32'h3FF) ^ int'(br_global_history);
    if (br_valid && br_is_cond && nv != pv) mq.push_back({idx[9:0], nv[1:0]});
  endtask

  task automatic idle(input logic rd);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 10'h0, 2'd0, rd);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle(1'b0);
    n_checks++;
    if (obs_status !== 10'b00_000000_0_1) begin
      n_fail++; $display("FAIL reset_state: got %b expected %b", obs_status, 10'b00_000000_0_1);
    end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_single();
    drive(1'b1, 1'b1, 1'b1, 32'h0000_1234, 10'h0F0, 2'd2, 1'b0); tick();
    idle(1'b0);
    n_checks++;
    if ({pht_we, pht_wa, pht_wv, pht_read_blocked} !== {1'b1, 10'h07D, 2'd3, 1'b0}) begin
      n_fail++; $display("FAIL single_write: got we=%0b wa=%h wv=%0d blk=%0b expected 1 07d 3 0",
                         pht_we, pht_wa, pht_wv, pht_read_blocked);
    end
    tick(); idle(1'b0);
    n_checks++;
    if (empty !== 1'b1) begin n_fail++; $display("FAIL single_empty: got %0b expected 1", empty); end
  endtask

  task automatic test_filter();
    drive(1'b1, 1'b1, 1'b1, 32'h0000_0040, 10'h003, 2'd3, 1'b0); tick();
    drive(1'b1, 1'b1, 1'b0, 32'h0000_0080, 10'h005, 2'd0, 1'b0); tick();
    drive(1'b1, 1'b0, 1'b1, 32'h0000_00C0, 10'h007, 2'd1, 1'b0); tick();
    for (int i = 0; i < 2; i++) begin
      idle(1'b0);
      n_checks++;
      if ({count, pht_we} !== {6'd0, 1'b0}) begin
        n_fail++; $display("FAIL filter: got count=%0d we=%0b expected 0 0", count, pht_we);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back_fill();
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 1'b1, 1'b1, 32'(i) << 2, 10'h0, 2'd1, 1'b1);
      n_checks++;
      if (obs_status !== exp_status) begin
        n_fail++; $display("FAIL fill_status: got %b expected %b", obs_status, exp_status);
      end
      tick();
    end
    drive(1'b1, 1'b1, 1'b1, 32'd32 << 2, 10'h0, 2'd1, 1'b1);
    n_checks++;
    if ({pht_we, pht_read_blocked, count, full} !== {1'b1, 1'b1, 6'd32, 1'b1}) begin
      n_fail++; $display("FAIL fill_forced: got we=%0b blk=%0b cnt=%0d full=%0b expected 1 1 32 1",
                         pht_we, pht_read_blocked, count, full);
    end
    tick();
    for (int i = 0; i < 32; i++) begin
      idle(1'b0);
      n_checks++;
      if (i == 0 && count !== 6'd32) begin
        n_fail++; $display("FAIL fill_kept: got count=%0d expected 32", count);
      end
      if (obs_status !== exp_status || obs_head !== exp_head || pht_we !== 1'b1) begin
        n_fail++; $display("FAIL fill_drain[%0d]: got %b/%h expected %b/%h", i, obs_status, obs_head,
                           exp_status, exp_head);
      end
      tick();
    end
    idle(1'b0);
    n_checks++;
    if (empty !== 1'b1) begin n_fail++; $display("FAIL fill_empty: got %0b expected 1", empty); end
  endtask

  task automatic test_wrap();
    logic t;
    for (int i = 0; i < 40; i++) begin
      t = 1'($urandom_range(0, 1));
      drive(1'b1, 1'b1, t, $urandom, 10'($urandom),
            t ? 2'($urandom_range(0, 2)) : 2'($urandom_range(1, 3)), 1'b0);
      n_checks++;
      if (obs_status !== exp_status || (exp_we && obs_head !== exp_head) || count > 6'd1) begin
        n_fail++; $display("FAIL wrap[%0d]: got %b/%h expected %b/%h", i, obs_status, obs_head,
                           exp_status, exp_head);
      end
      tick();
    end
    idle(1'b0); tick();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 1'b0, 32'(i + 100) << 2, 10'h155, 2'd3, 1'b1); tick();
    end
    idle(1'b1);
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({count, empty, pht_we} !== {6'd0, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL reset_mid: got count=%0d empty=%0b we=%0b expected 0 1 0", count, empty, pht_we);
    end
    mq.delete();
    @(negedge clk); rst = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 32'h0000_0008, 10'h000, 2'd0, 1'b0); tick();
    idle(1'b0);
    n_checks++;
    if ({pht_we, pht_wa, pht_wv, count} !== {1'b1, 10'h002, 2'd1, 6'd1}) begin
      n_fail++; $display("FAIL reset_fresh: got we=%0b wa=%h wv=%0d cnt=%0d expected 1 002 1 1",
                         pht_we, pht_wa, pht_wv, count);
    end
    tick(); idle(1'b0);
    n_checks++;
    if ({empty, pht_we} !== 2'b10) begin
      n_fail++; $display("FAIL reset_stale: got empty=%0b we=%0b expected 1 0", empty, pht_we);
    end
    tick();
  endtask

  task automatic test_decrement();
    drive(1'b1, 1'b1, 1'b0, 32'h0000_0400, 10'h001, 2'd2, 1'b0); tick();
    idle(1'b0);
    n_checks++;
    if ({pht_we, pht_wa, pht_wv} !== {1'b1, 10'h101, 2'd1}) begin
      n_fail++; $display("FAIL decrement: got we=%0b wa=%h wv=%0d expected 1 101 1", pht_we, pht_wa, pht_wv);
    end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 5) != 0), 1'($urandom_range(0, 1)),
            $urandom, 10'($urandom), 2'($urandom), 1'($urandom_range(0, 9) < ((i / 100) % 2 == 0 ? 9 : 3)));
      n_checks++;
      if (obs_status !== exp_status || (exp_we && obs_head !== exp_head)) begin
        n_fail++; $display("FAIL random[%0d]: got %b/%h expected %b/%h", i, obs_status, obs_head,
                           exp_status, exp_head);
      end
      tick();
    end
  endtask

  initial begin
    br_valid = 1'b0; br_is_cond = 1'b0; br_exec_taken = 1'b0; br_addr = 32'h0;
    br_global_history = 10'h0; br_pht_prev = 2'd0; pht_read_req = 1'b0;
    test_reset();
    test_single();
    test_filter();
    test_back_to_back_fill();
    test_wrap();
    test_reset_mid();
    test_decrement();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pht_update_queue.md
Name: pht_update_queue

Overview:
- Sits directly downstream of branch resolution and directly upstream of the gshare PHT block RAM.
- Consumes per-branch results (address, global history, previous counter value, actual direction) and computes each updated 2-bit saturating counter and its gshare index.
- Buffers the resulting write requests in a FIFO and drains them into the single-ported PHT only when fetch is not reading, except when the queue is full.

Parameters:
QUEUE_SIZE, 32, FIFO depth (power of two, >= 2)
PC_WIDTH, 32, branch address width
INSN_ADDR_BIT_WIDTH, 2, low PC bits dropped before indexing
PHT_INDEX_WIDTH, 10, log2 of PHT entry count
GHR_WIDTH, 10, global history width (<= PHT_INDEX_WIDTH)
COUNTER_WIDTH, 2, PHT counter width

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
br_valid  in  1  branch result valid this cycle
br_is_cond  in  1  result is a conditional branch
br_exec_taken  in  1  resolved direction
br_addr  in  PC_WIDTH  branch PC
br_global_history  in  GHR_WIDTH  history used at prediction
br_pht_prev  in  COUNTER_WIDTH  counter value read at prediction
pht_read_req  in  1  fetch needs the PHT port this cycle
pht_we  out  1  PHT write enable
pht_wa  out  PHT_INDEX_WIDTH  PHT write index (head entry)
pht_wv  out  COUNTER_WIDTH  PHT write value (head entry)
pht_read_blocked  out  1  write overrides a fetch read this cycle
count  out  $clog2(QUEUE_SIZE+1)  occupancy
full  out  1  count == QUEUE_SIZE
empty  out  1  count == 0

Behaviour:
- Reset: while rst is low, asynchronously clear head, tail and count. Outputs are then: count=0, empty=1, full=0, pht_we=0, pht_read_blocked=0. pht_wa and pht_wv are don't-care while pht_we=0. Storage contents are not cleared.
- Index: idx = br_addr[INSN_ADDR_BIT_WIDTH+PHT_INDEX_WIDTH-1 : INSN_ADDR_BIT_WIDTH] XOR zero-extend(br_global_history).
- New value:
  - taken: min(prev+1, 2^COUNTER_WIDTH-1).
  - not taken: max(prev-1, 0).
  - No wrap.
- Enqueue condition: br_valid & br_is_cond & (new != prev). Saturated no-change results and unconditional branches are filtered and never enqueued.
- Drain: pht_we = !empty & (!pht_read_req | full). This is combinational from registered state and pht_read_req.
  - pht_read_blocked = pht_we & pht_read_req.
  - A dequeue occurs on every cycle with pht_we=1.
- Latency:
  - A result presented in cycle T is written into storage at the T edge.
  - Earliest appearance on pht_wa/pht_wv is cycle T+1.
  - No bypass from input to write port.
- Order: strict FIFO. Duplicate indices are not merged; later entries overwrite earlier ones in RAM order.
- Full: a forced drain always happens, so an enqueue in the same cycle is always accepted and no update is ever dropped.
- Simultaneous enqueue and dequeue: count unchanged. Allowed at any occupancy, including full and 1.
- Empty with an enqueue: pht_we stays 0 that cycle; the entry is writable next cycle.
- Pointers are log2(QUEUE_SIZE) bits and wrap naturally. count is separate and saturates only by construction.
- Assertion: count never exceeds QUEUE_SIZE.

Test Plan:
1. Single update, PHT port idle: br_addr=0x00001234, history=0x0F0, prev=2, taken, pht_read_req=0 -> cycle T+1: pht_we=1, pht_wa=0x07D, pht_wv=3, pht_read_blocked=0; cycle T+2: empty=1.
2. Filtering: prev=3 taken; prev=0 not-taken; br_is_cond=0 with prev=1 taken -> count stays 0, pht_we never asserted.
3. Fill under read pressure: pht_read_req=1 held, 32 distinct updates on consecutive cycles -> pht_we=0 until count=32, full=1. Next cycle: pht_we=1 and pht_read_blocked=1. A 33rd update that cycle keeps count=32. Drop pht_read_req -> 32 writes on consecutive cycles in enqueue order, then empty=1.
4. Wrap-around: 40 updates with pht_read_req=0, one per cycle -> count toggles 0/1, writes emerge in order with correct values across the pointer wrap.
5. Reset mid-operation: 5 entries queued, rst pulled low asynchronously between edges -> count=0, empty=1, pht_we=0 immediately. After release, a new update is written alone at T+1 with no stale entries.
6. Decrement path: prev=2 not-taken, br_addr=0x00000400, history=0x001 -> pht_wa=0x101, pht_wv=1.
